// File: rtl/uart_console_writer.sv
// Terminal-style writer: drains the UART RX FIFO into character RAM, tracking a cursor.
// Define CONSOLE_SCROLL_EN for ring-buffer scrolling via top_row; otherwise rows wrap in place.
module uart_console_writer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_present,
   output logic              rx_read,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [6:0]        cursor_col,
   output logic [4:0]        cursor_row,
   output logic [4:0]        top_row,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EXEC, CLR_LINE, CLR_SCR} state_t;

   state_t            state, state_d;
   logic              run;
   logic [7:0]        ch, ch_d;
   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_addr_d, cnt, cnt_d;
   logic [7:0]        wr_data_d;
   logic [6:0]        col_d;
   logic [4:0]        row_d, new_row;
   logic              newline;
`ifdef CONSOLE_SCROLL_EN
   logic [4:0]        top_q, top_d;
   logic              full, full_d;
`endif

   function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] r);
      return ADDR_W'(r) * ADDR_W'(COLS);
   endfunction

   function automatic logic is_print(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

   // Write strobes are decided when the byte is popped so they appear during EXEC.
   always_comb begin
      state_d   = state;
      ch_d      = ch;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      cnt_d     = cnt;
      col_d     = cursor_col;
      row_d     = cursor_row;
      newline   = 1'b0;
`ifdef CONSOLE_SCROLL_EN
      top_d     = top_q;
      full_d    = full;
`endif
      new_row = (cursor_row == 5'(ROWS - 1)) ? 5'd0 : cursor_row + 5'd1;
      rx_read = run && (state == IDLE) && rx_present;

      case (state)
         IDLE: begin
            if (rx_read) begin
               ch_d    = rx_data;
               state_d = EXEC;
               if (is_print(rx_data)) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = rx_data;
                  wr_addr_d = row_base(cursor_row) + ADDR_W'(cursor_col);
               end else if (rx_data == 8'h08 && cursor_col != 7'd0) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = 8'h20;
                  wr_addr_d = row_base(cursor_row) + ADDR_W'(cursor_col - 7'd1);
               end
            end
         end
         EXEC: begin
            state_d = IDLE;
            if (is_print(ch)) begin
               if (cursor_col == 7'(COLS - 1)) begin
                  col_d   = 7'd0;
                  newline = 1'b1;
               end else begin
                  col_d = cursor_col + 7'd1;
               end
            end else begin
               case (ch)
                  8'h0D: col_d = 7'd0;
                  8'h0A: newline = 1'b1;
                  8'h08: if (cursor_col != 7'd0) col_d = cursor_col - 7'd1;
                  8'h0C: begin
                     state_d   = CLR_SCR;
                     wr_en_d   = 1'b1;
                     wr_data_d = 8'h20;
                     wr_addr_d = '0;
                     cnt_d     = '0;
                     col_d     = 7'd0;
                     row_d     = 5'd0;
`ifdef CONSOLE_SCROLL_EN
                     top_d     = 5'd0;
                     full_d    = 1'b0;
`endif
                  end
                  default: ;
               endcase
            end
            if (newline) begin
               row_d = new_row;
`ifdef CONSOLE_SCROLL_EN
               // Once the ring has filled, every new line becomes the bottom line and is blanked.
               if (full || cursor_row == 5'(ROWS - 1)) begin
                  full_d    = 1'b1;
                  top_d     = (new_row == 5'(ROWS - 1)) ? 5'd0 : new_row + 5'd1;
                  state_d   = CLR_LINE;
                  wr_en_d   = 1'b1;
                  wr_data_d = 8'h20;
                  wr_addr_d = row_base(new_row);
                  cnt_d     = '0;
               end
`endif
            end
         end
         CLR_LINE: begin
            if (cnt == ADDR_W'(COLS - 1)) begin
               state_d = IDLE;
            end else begin
               wr_en_d   = 1'b1;
               cnt_d     = cnt + 1'b1;
               wr_addr_d = wr_addr + 1'b1;
            end
         end
         CLR_SCR: begin
            if (cnt == ADDR_W'(COLS * ROWS - 1)) begin
               state_d = IDLE;
            end else begin
               wr_en_d   = 1'b1;
               cnt_d     = cnt + 1'b1;
               wr_addr_d = wr_addr + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         run        <= 1'b0;
         ch         <= 8'h00;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'h00;
         cnt        <= '0;
         cursor_col <= 7'd0;
         cursor_row <= 5'd0;
`ifdef CONSOLE_SCROLL_EN
         top_q      <= 5'd0;
         full       <= 1'b0;
`endif
      end else begin
         state      <= state_d;
         run        <= 1'b1;
         ch         <= ch_d;
         wr_en      <= wr_en_d;
         wr_addr    <= wr_addr_d;
         wr_data    <= wr_data_d;
         cnt        <= cnt_d;
         cursor_col <= col_d;
         cursor_row <= row_d;
`ifdef CONSOLE_SCROLL_EN
         top_q      <= top_d;
         full       <= full_d;
`endif
      end
   end

`ifdef CONSOLE_SCROLL_EN
   assign top_row = top_q;
`else
   assign top_row = 5'd0;
`endif
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_console_writer.sv
// Directed bench for uart_console_writer: printable writes, wrap, BS/CR/LF/FF, clears, reset abort.
module tb_uart_console_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_present = 1'b0;
   logic        rx_read, wr_en, busy;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row, top_row;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   uart_console_writer #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_present(rx_present),
      .rx_read(rx_read), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .top_row(top_row), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a byte, wait (bounded) for the pop, and return positioned in the EXEC cycle.
   task automatic send(input logic [7:0] b);
      int waited;
      waited     = 0;
      rx_data    = b;
      rx_present = 1'b1;
      #1;
      while (!rx_read && waited < 100) begin
         @(posedge clk);
         #2;
         waited++;
      end
      check("pop_seen", {31'd0, rx_read}, 32'd1);
      @(posedge clk);
      #1;
      rx_present = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_read"}, {31'd0, rx_read}, 32'd0);
      check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      check({tag, "_wr_addr"}, {20'd0, wr_addr}, 32'd0);
      check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
      check({tag, "_col"}, {25'd0, cursor_col}, 32'd0);
      check({tag, "_row"}, {27'd0, cursor_row}, 32'd0);
      check({tag, "_top"}, {27'd0, top_row}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int bad;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // Single printable byte at (0,0)
      send(8'h41);
      check("a_wr_en", {31'd0, wr_en}, 32'd1);
      check("a_addr", {20'd0, wr_addr}, 32'd0);
      check("a_data", {24'd0, wr_data}, 32'h41);
      check("a_busy", {31'd0, busy}, 32'd1);
      step();
      check("a_col", {25'd0, cursor_col}, 32'd1);
      check("a_idle", {31'd0, busy}, 32'd0);

      // Fill the rest of row 0; the 80th byte wraps the cursor
      for (int i = 1; i < 80; i++) send(8'h41 + 8'(i % 26));
      check("wrap_addr", {20'd0, wr_addr}, 32'd79);
      check("wrap_data", {24'd0, wr_data}, 32'h42);
      step();
      check("wrap_row", {27'd0, cursor_row}, 32'd1);
      check("wrap_col", {25'd0, cursor_col}, 32'd0);
      check("wrap_noclr", {31'd0, busy}, 32'd0);
      check("wrap_nowr", {31'd0, wr_en}, 32'd0);

      // Move to (5,3) and backspace
      repeat (4) send(8'h0A);
      repeat (3) send(8'h78);
      send(8'h08);
      check("bs_wr_en", {31'd0, wr_en}, 32'd1);
      check("bs_addr", {20'd0, wr_addr}, 32'd402);
      check("bs_data", {24'd0, wr_data}, 32'h20);
      step();
      check("bs_col", {25'd0, cursor_col}, 32'd2);
      check("bs_row", {27'd0, cursor_row}, 32'd5);

      // CR, then backspace at column 0 writes nothing
      send(8'h0D);
      send(8'h08);
      check("bs0_nowr", {31'd0, wr_en}, 32'd0);
      step();
      check("bs0_col", {25'd0, cursor_col}, 32'd0);

      // Walk to the last row, then one more LF
      repeat (24) send(8'h0A);
      step();
      check("lf_row29", {27'd0, cursor_row}, 32'd29);
      send(8'h0A);
      step();
      check("lf30_row", {27'd0, cursor_row}, 32'd0);
`ifdef CONSOLE_SCROLL_EN
      check("lf30_top", {27'd0, top_row}, 32'd1);
      bad = 0;
      for (int k = 0; k < 80; k++) begin
         if (wr_en !== 1'b1 || wr_addr !== 12'(k) || wr_data !== 8'h20 || busy !== 1'b1) bad++;
         step();
      end
      check("clr_line_writes", bad, 32'd0);
      check("clr_line_done", {31'd0, busy}, 32'd0);
      check("clr_line_wr_off", {31'd0, wr_en}, 32'd0);
`else
      check("lf30_top", {27'd0, top_row}, 32'd0);
      check("lf30_noclr", {31'd0, busy}, 32'd0);
      check("lf30_nowr", {31'd0, wr_en}, 32'd0);
`endif

      // Form feed with a byte queued during the clear
      send(8'h5A);
      check("z_addr", {20'd0, wr_addr}, 32'd0);
      send(8'h0C);
      check("ff_exec_nowr", {31'd0, wr_en}, 32'd0);
      rx_data    = 8'h51;
      rx_present = 1'b1;
      step();
      check("ff_col", {25'd0, cursor_col}, 32'd0);
      check("ff_row", {27'd0, cursor_row}, 32'd0);
      check("ff_top", {27'd0, top_row}, 32'd0);
      check("ff_busy", {31'd0, busy}, 32'd1);
      bad = 0;
      for (int k = 0; k < 2400; k++) begin
         if (wr_en !== 1'b1 || wr_addr !== 12'(k) || wr_data !== 8'h20 || rx_read !== 1'b0) bad++;
         step();
      end
      check("clr_scr_writes", bad, 32'd0);
      check("clr_scr_done", {31'd0, busy}, 32'd0);
      check("clr_scr_wr_off", {31'd0, wr_en}, 32'd0);
      check("queued_pop", {31'd0, rx_read}, 32'd1);
      step();
      rx_present = 1'b0;
      check("q_wr_en", {31'd0, wr_en}, 32'd1);
      check("q_addr", {20'd0, wr_addr}, 32'd0);
      check("q_data", {24'd0, wr_data}, 32'h51);
      step();
      check("q_col", {25'd0, cursor_col}, 32'd1);

      // Reset in the middle of a screen clear
      send(8'h0C);
      step();
      repeat (1000) step();
      check("mid_clr_addr", {20'd0, wr_addr}, 32'd1000);
      rx_data    = 8'h42;
      rx_present = 1'b1;
      rst_n      = 1'b0;
      #1;
      check_reset_outputs("abort");
      step();
      rst_n = 1'b1;
      send(8'h42);
      check("post_wr_en", {31'd0, wr_en}, 32'd1);
      check("post_addr", {20'd0, wr_addr}, 32'd0);
      check("post_data", {24'd0, wr_data}, 32'h42);
      step();
      check("post_col", {25'd0, cursor_col}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
